multicycle_control: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle control decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states with a memory ready handshake.
- Traps on illegal opcodes and on memory timeouts, and counts retired instructions.
- Sits between the instruction register and the shared-memory multicycle datapath.

---
 rtl/multicycle_control.sv | 227 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle control unit for the shared-memory datapath.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB, waits on the
// memory ready handshake, traps on illegal opcodes or memory timeouts and
// counts retired instructions. Datapath strobes are decoded from the
// registered state; the few fetch strobes that must follow mem_ready in
// the same cycle are Mealy terms.
module multicycle_control #(
  parameter int OP_WIDTH  = 2,
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [OP_WIDTH-1:0]  opcode,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 ir_write,
  output logic                 i_or_d,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 mem_to_reg,
  output logic                 reg_dst,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 pc_source,
  output logic [2:0]           state,
  output logic                 trap,
  output logic [CNT_WIDTH-1:0] retired
);

  // Wait counter only ever needs to hold TIMEOUT-1; keep at least one bit
  // so the declaration stays legal when the timeout is disabled.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [OP_WIDTH-1:0] OP_R   = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_LW  = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_SW  = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_BEQ = OP_WIDTH'(3);

  // Any opcode bit above the low two makes the instruction illegal.
  localparam logic [OP_WIDTH-1:0] OP_HIGH_MASK = ~OP_WIDTH'(3);

  // ALU source / operation encodings seen by the datapath.
  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_ONE    = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_BRANCH = 2'b11;
  localparam logic [1:0] ALU_ADD      = 2'b00;
  localparam logic [1:0] ALU_SUB      = 2'b01;
  localparam logic [1:0] ALU_FUNCT    = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  state_t                 state_reg;
  logic [OP_WIDTH-1:0]    op_reg;
  logic [WAIT_W-1:0]      wait_reg;
  logic [CNT_WIDTH-1:0]   retired_reg;

  logic opcode_legal;
  logic waiting;
  logic timed_out;

  // Legality is judged on the live opcode because it is sampled in DECODE.
  assign opcode_legal = ((opcode & OP_HIGH_MASK) == '0);

  // A memory request is outstanding in FETCH (when running) and in MEM.
  assign waiting = ((state_reg == S_FETCH) && run) || (state_reg == S_MEM);

  // The TIMEOUT-th consecutive cycle without mem_ready gives up; a ready on
  // that same cycle still wins because timed_out requires mem_ready=0.
  assign timed_out = (TIMEOUT > 0) && waiting && !mem_ready &&
                     (wait_reg == WAIT_W'(TIMEOUT - 1));

  // State sequencing, opcode latch, wait counter and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      op_reg      <= '0;
      wait_reg    <= '0;
      retired_reg <= '0;
    end else begin
      // The wait counter is cleared on every cycle that is not a stalled
      // request, so it always starts from zero on entry to FETCH or MEM.
      wait_reg <= '0;
      case (state_reg)
        S_FETCH: begin
          if (run) begin
            if (mem_ready) begin
              state_reg <= S_DECODE;
            end else if (timed_out) begin
              state_reg <= S_TRAP;
            end else if (TIMEOUT > 0) begin
              wait_reg <= wait_reg + 1'b1;
            end
          end
        end
        S_DECODE: begin
          op_reg    <= opcode;
          state_reg <= opcode_legal ? S_EXEC : S_TRAP;
        end
        S_EXEC: begin
          case (op_reg)
            OP_R:         state_reg <= S_WB;
            OP_LW, OP_SW: state_reg <= S_MEM;
            OP_BEQ: begin
              state_reg   <= S_FETCH;
              retired_reg <= retired_reg + 1'b1;
            end
            default:      state_reg <= S_TRAP;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (op_reg == OP_LW) begin
              state_reg <= S_WB;
            end else begin
              state_reg   <= S_FETCH;
              retired_reg <= retired_reg + 1'b1;
            end
          end else if (timed_out) begin
            state_reg <= S_TRAP;
          end else if (TIMEOUT > 0) begin
            wait_reg <= wait_reg + 1'b1;
          end
        end
        S_WB: begin
          state_reg   <= S_FETCH;
          retired_reg <= retired_reg + 1'b1;
        end
        S_TRAP: begin
          state_reg <= S_TRAP;
        end
        default: begin
          state_reg <= S_FETCH;
        end
      endcase
    end
  end

  // Datapath strobes decoded from the current state and latched opcode.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_REG;
    alu_op        = ALU_ADD;
    pc_source     = 1'b0;
    case (state_reg)
      S_FETCH: begin
        if (run) begin
          mem_read  = 1'b1;
          i_or_d    = 1'b0;
          alu_src_a = 1'b0;
          alu_src_b = SRC_B_ONE;
          alu_op    = ALU_ADD;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
      end
      S_DECODE: begin
        alu_src_a = 1'b0;
        alu_src_b = SRC_B_BRANCH;
        alu_op    = ALU_ADD;
      end
      S_EXEC: begin
        case (op_reg)
          OP_R: begin
            alu_src_a = 1'b1;
            alu_src_b = SRC_B_REG;
            alu_op    = ALU_FUNCT;
          end
          OP_LW, OP_SW: begin
            alu_src_a = 1'b1;
            alu_src_b = SRC_B_IMM;
            alu_op    = ALU_ADD;
          end
          OP_BEQ: begin
            alu_src_a     = 1'b1;
            alu_src_b     = SRC_B_REG;
            alu_op        = ALU_SUB;
            pc_write_cond = 1'b1;
            pc_source     = 1'b1;
          end
          default: begin
            alu_src_a = 1'b0;
          end
        endcase
      end
      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = (op_reg == OP_LW);
        mem_write = (op_reg == OP_SW);
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (op_reg == OP_R);
        mem_to_reg = (op_reg == OP_LW);
      end
      default: begin
        pc_write = 1'b0;
      end
    endcase
  end

  assign state   = state_reg;
  assign trap    = (state_reg == S_TRAP);
  assign retired = retired_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a per-cycle vector table covering
// R-type, LW with memory stalls, SW and BEQ back to back and counter wrap,
// followed by hand sequences for timeouts, illegal opcodes and reset.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic       run;
  logic [2:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, pc_source;
  logic [1:0] alu_src_b, alu_op;
  logic [2:0] state;
  logic       trap;
  logic [1:0] retired;

  int total = 0;
  int bad   = 0;

  multicycle_control #(
    .OP_WIDTH (3),
    .CNT_WIDTH(2),
    .TIMEOUT  (15)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .ir_write     (ir_write),
    .i_or_d       (i_or_d),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_to_reg   (mem_to_reg),
    .reg_dst      (reg_dst),
    .reg_write    (reg_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .pc_source    (pc_source),
    .state        (state),
    .trap         (trap),
    .retired      (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe bundle bit positions (MSB first):
  // pc_write pc_write_cond ir_write i_or_d mem_read mem_write mem_to_reg
  // reg_dst reg_write alu_src_a alu_src_b[1:0] alu_op[1:0] pc_source
  localparam logic [14:0] B_PCW  = 15'h4000;
  localparam logic [14:0] B_PCC  = 15'h2000;
  localparam logic [14:0] B_IRW  = 15'h1000;
  localparam logic [14:0] B_IOD  = 15'h0800;
  localparam logic [14:0] B_MRD  = 15'h0400;
  localparam logic [14:0] B_MWR  = 15'h0200;
  localparam logic [14:0] B_M2R  = 15'h0100;
  localparam logic [14:0] B_RDST = 15'h0080;
  localparam logic [14:0] B_RWR  = 15'h0040;
  localparam logic [14:0] B_ASA  = 15'h0020;
  localparam logic [14:0] B_SB1  = 15'h0008;
  localparam logic [14:0] B_SB2  = 15'h0010;
  localparam logic [14:0] B_SB3  = 15'h0018;
  localparam logic [14:0] B_SUB  = 15'h0002;
  localparam logic [14:0] B_FN   = 15'h0004;
  localparam logic [14:0] B_PCS  = 15'h0001;

  localparam logic [14:0] IDLE   = 15'h0000;
  localparam logic [14:0] F_WAIT = B_MRD | B_SB1;
  localparam logic [14:0] F_GO   = F_WAIT | B_PCW | B_IRW;
  localparam logic [14:0] DEC    = B_SB3;
  localparam logic [14:0] EX_R   = B_ASA | B_FN;
  localparam logic [14:0] EX_M   = B_ASA | B_SB2;
  localparam logic [14:0] EX_B   = B_ASA | B_SUB | B_PCC | B_PCS;
  localparam logic [14:0] MEM_LW = B_IOD | B_MRD;
  localparam logic [14:0] MEM_SW = B_IOD | B_MWR;
  localparam logic [14:0] WB_R   = B_RWR | B_RDST;
  localparam logic [14:0] WB_LW  = B_RWR | B_M2R;

  typedef struct packed {
    logic        rst;
    logic        run;
    logic [2:0]  op;
    logic        rdy;
    logic [2:0]  st;
    logic [14:0] strb;
    logic        trp;
    logic [1:0]  ret;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic rst_i, input logic run_i,
                              input logic [2:0] op_i, input logic rdy_i,
                              input logic [2:0] st_i, input logic [14:0] strb_i,
                              input logic trp_i, input logic [1:0] ret_i);
    vec_t v;
    v.rst  = rst_i;
    v.run  = run_i;
    v.op   = op_i;
    v.rdy  = rdy_i;
    v.st   = st_i;
    v.strb = strb_i;
    v.trp  = trp_i;
    v.ret  = ret_i;
    return v;
  endfunction

  function automatic logic [14:0] strobes();
    return {pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
            mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
            pc_source};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst_i, input logic run_i,
                       input logic [2:0] op_i, input logic rdy_i);
    reset     = rst_i;
    run       = run_i;
    opcode    = op_i;
    mem_ready = rdy_i;
    #3;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Table: one row per clock; outputs checked before the row's edge.
    vecs[0]  = mk(1, 0, 0, 0, 3'd0, IDLE,   0, 2'd0);
    vecs[1]  = mk(0, 1, 0, 1, 3'd0, F_GO,   0, 2'd0);
    vecs[2]  = mk(0, 0, 0, 1, 3'd1, DEC,    0, 2'd0);
    vecs[3]  = mk(0, 1, 3, 0, 3'd2, EX_R,   0, 2'd0);
    vecs[4]  = mk(0, 0, 2, 0, 3'd4, WB_R,   0, 2'd0);
    vecs[5]  = mk(0, 0, 0, 0, 3'd0, IDLE,   0, 2'd1);
    vecs[6]  = mk(0, 1, 0, 1, 3'd0, F_GO,   0, 2'd1);
    vecs[7]  = mk(0, 1, 1, 0, 3'd1, DEC,    0, 2'd1);
    vecs[8]  = mk(0, 1, 0, 1, 3'd2, EX_M,   0, 2'd1);
    vecs[9]  = mk(0, 1, 0, 0, 3'd3, MEM_LW, 0, 2'd1);
    vecs[10] = mk(0, 1, 0, 0, 3'd3, MEM_LW, 0, 2'd1);
    vecs[11] = mk(0, 1, 0, 0, 3'd3, MEM_LW, 0, 2'd1);
    vecs[12] = mk(0, 1, 0, 1, 3'd3, MEM_LW, 0, 2'd1);
    vecs[13] = mk(0, 1, 0, 0, 3'd4, WB_LW,  0, 2'd1);
    vecs[14] = mk(0, 1, 2, 1, 3'd0, F_GO,   0, 2'd2);
    vecs[15] = mk(0, 1, 2, 1, 3'd1, DEC,    0, 2'd2);
    vecs[16] = mk(0, 1, 0, 1, 3'd2, EX_M,   0, 2'd2);
    vecs[17] = mk(0, 1, 0, 1, 3'd3, MEM_SW, 0, 2'd2);
    vecs[18] = mk(0, 1, 3, 1, 3'd0, F_GO,   0, 2'd3);
    vecs[19] = mk(0, 1, 3, 1, 3'd1, DEC,    0, 2'd3);
    vecs[20] = mk(0, 1, 1, 1, 3'd2, EX_B,   0, 2'd3);
    vecs[21] = mk(0, 0, 0, 0, 3'd0, IDLE,   0, 2'd0);

    drive(1, 0, 0, 0);
    tick();
    tick();

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst, vecs[i].run, vecs[i].op, vecs[i].rdy);
      chk($sformatf("vec%0d state", i),   32'(state),     32'(vecs[i].st));
      chk($sformatf("vec%0d strobes", i), 32'(strobes()), 32'(vecs[i].strb));
      chk($sformatf("vec%0d trap", i),    32'(trap),      32'(vecs[i].trp));
      chk($sformatf("vec%0d retired", i), 32'(retired),   32'(vecs[i].ret));
      $display("vec %0d: state=%0d strobes=%04h trap=%0b retired=%0d",
               i, state, strobes(), trap, retired);
      tick();
    end

    // Five R-type instructions on a 2-bit counter: 1,2,3,0,1.
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 1);
      tick();
      tick();
      tick();
      tick();
      drive(0, 1, 0, 1);
      chk($sformatf("wrap%0d state", i), 32'(state), 32'd0);
      chk($sformatf("wrap%0d retired", i), 32'(retired), 32'((i + 1) % 4));
      $display("rtype %0d: retired=%0d", i, retired);
    end

    // Fetch stalls for the full timeout window -> TRAP.
    for (int k = 1; k <= 15; k++) begin
      drive(0, 1, 0, 0);
      chk($sformatf("tmo cyc%0d state", k), 32'(state), 32'd0);
      chk($sformatf("tmo cyc%0d strobes", k), 32'(strobes()), 32'(F_WAIT));
      tick();
    end
    drive(0, 1, 0, 1);
    chk("tmo trap state", 32'(state), 32'd7);
    chk("tmo trap flag", 32'(trap), 32'd1);
    $display("fetch timeout: state=%0d trap=%0b", state, trap);
    for (int k = 0; k < 20; k++) begin
      drive(0, 1, 3'(k), 1'(k));
      chk($sformatf("tmo hold%0d", k), 32'({state, trap, strobes(), retired}),
          32'({3'd7, 1'b1, IDLE, 2'd1}));
      tick();
    end

    // Reset releases the trap.
    drive(1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    chk("rst state", 32'(state), 32'd0);
    chk("rst trap", 32'(trap), 32'd0);
    chk("rst retired", 32'(retired), 32'd0);
    chk("rst strobes", 32'(strobes()), 32'(IDLE));
    $display("reset after trap: state=%0d trap=%0b", state, trap);

    // Ready on the last allowed fetch cycle wins over the timeout, then a
    // LW whose MEM phase also stalls 14 cycles before ready arrives.
    for (int k = 1; k <= 14; k++) begin
      drive(0, 1, 0, 0);
      tick();
    end
    drive(0, 1, 0, 1);
    chk("edge fetch strobes", 32'(strobes()), 32'(F_GO));
    tick();
    drive(0, 1, 1, 0);
    chk("edge decode state", 32'(state), 32'd1);
    tick();
    drive(0, 1, 0, 0);
    tick();
    for (int k = 1; k <= 14; k++) begin
      drive(0, 1, 0, 0);
      tick();
    end
    drive(0, 1, 0, 1);
    chk("edge mem state", 32'(state), 32'd3);
    chk("edge mem strobes", 32'(strobes()), 32'(MEM_LW));
    tick();
    drive(0, 0, 0, 0);
    chk("edge wb state", 32'(state), 32'd4);
    tick();
    drive(0, 0, 0, 0);
    chk("edge retired", 32'(retired), 32'd1);
    chk("edge no trap", 32'(trap), 32'd0);
    $display("timeout edge: state=%0d retired=%0d", state, retired);

    // Illegal opcode 5 in DECODE -> TRAP.
    drive(0, 1, 0, 1);
    tick();
    drive(0, 1, 5, 1);
    chk("ill decode state", 32'(state), 32'd1);
    tick();
    for (int k = 0; k < 20; k++) begin
      drive(0, 1, 3'(k), 1'b1);
      chk($sformatf("ill hold%0d", k), 32'({state, trap, strobes(), retired}),
          32'({3'd7, 1'b1, IDLE, 2'd1}));
      tick();
    end
    $display("illegal opcode: state=%0d trap=%0b", state, trap);
    drive(1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    chk("ill rst state", 32'(state), 32'd0);
    chk("ill rst trap", 32'(trap), 32'd0);

    // One R-type, then reset in the middle of a stalled LW.
    drive(0, 1, 0, 1);
    tick();
    tick();
    tick();
    tick();
    drive(0, 1, 0, 1);
    chk("mid pre retired", 32'(retired), 32'd1);
    tick();
    drive(0, 1, 1, 0);
    tick();
    tick();
    drive(0, 1, 0, 0);
    chk("mid mem state", 32'(state), 32'd3);
    chk("mid mem read", 32'(mem_read), 32'd1);
    tick();
    drive(1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    chk("mid rst state", 32'(state), 32'd0);
    chk("mid rst retired", 32'(retired), 32'd0);
    chk("mid rst mem_read", 32'(mem_read), 32'd0);
    chk("mid rst strobes", 32'(strobes()), 32'(IDLE));
    $display("reset mid-MEM: state=%0d retired=%0d mem_read=%0b",
             state, retired, mem_read);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
